pipe_hazard_ctrl: RTL and testbench

Sequencing controller for the 5-stage CPU pipeline (IF/ID/EX/MEM/WB) driven by the serial debug unit. It owns run control: halt, run, single-step and a PC breakpoint. It detects load-use hazards and branch/jump redirects (PCSrc from EX) and produces per-stage write-enables and flushes. It also drives the EX operand forwarding selects and keeps cycle and stall counters for debug readback.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 49 ++++
 rtl/pipe_hazard_ctrl_if.sv | 57 +++++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller:
// run-control states, forwarding selects, control-word bit positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam int CTR_BRANCH   = 0;
  localparam int CTR_MEMREAD  = 1;
  localparam int CTR_REGWRITE = 7;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [4:0] rd_of(input logic [31:0] ir);
    return ir[11:7];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] ir);
    return ir[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] ir);
    return ir[24:20];
  endfunction

  // The younger producer (MEM) shadows the older one (WB) for the same register.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       mem_wr,
                                         input logic [4:0] rd_mem,
                                         input logic       wb_wr,
                                         input logic [4:0] rd_wb);
    logic [1:0] sel;
    sel = FWD_REG;
    if (mem_wr && (rd_mem != 5'd0) && (rd_mem == rs)) begin
      sel = FWD_MEM;
    end else if (wb_wr && (rd_wb != 5'd0) && (rd_wb == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline/debug unit (master) and the hazard
// controller (slave); clock and reset travel as plain ports.
interface pipe_hazard_ctrl_if import pipe_pkg::*; #(
  parameter int CNT_W = 32
) ();

  // run_req/step_req/halt_req are one-cycle pulses sampled on clk_cpu and
  // always accepted (no ready); every enable/flush is a level qualifier for
  // the same clock edge on which it is asserted.
  logic             run_req;
  logic             step_req;
  logic             halt_req;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc_if;
  logic [31:0]      ir_id;
  logic [31:0]      ir_ex;
  logic [7:0]       ctr_ex;
  logic [31:0]      ir_mem;
  logic [7:0]       ctr_mem;
  logic [31:0]      ir_wb;
  logic [7:0]       ctr_wb;
  logic             pcsrc;

  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_we;
  logic             idex_flush;
  logic             exmem_we;
  logic             memwb_we;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             running;
  logic             halted;
  logic             bp_hit;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  state_t           dbg_state;

  modport master (
    output run_req, step_req, halt_req, bp_en, bp_addr, pc_if,
           ir_id, ir_ex, ctr_ex, ir_mem, ctr_mem, ir_wb, ctr_wb, pcsrc,
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
           memwb_we, fwd_a, fwd_b, running, halted, bp_hit,
           cycle_cnt, stall_cnt, dbg_state
  );

  modport slave (
    input  run_req, step_req, halt_req, bp_en, bp_addr, pc_if,
           ir_id, ir_ex, ctr_ex, ir_mem, ctr_mem, ir_wb, ctr_wb, pcsrc,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
           memwb_we, fwd_a, fwd_b, running, halted, bp_hit,
           cycle_cnt, stall_cnt, dbg_state
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX operand forwarding selects from the MEM and WB destination registers.
// Purely combinational and independent of run control.
module fwd_unit import pipe_pkg::*; (
  input  logic [31:0] i_ir_ex,
  input  logic [31:0] i_ir_mem,
  input  logic [7:0]  i_ctr_mem,
  input  logic [31:0] i_ir_wb,
  input  logic [7:0]  i_ctr_wb,
  output logic [1:0]  o_fwd_a,
  output logic [1:0]  o_fwd_b
);

  logic [4:0] w_rd_mem;
  logic [4:0] w_rd_wb;
  logic       w_unused;

  assign w_rd_mem = rd_of(i_ir_mem);
  assign w_rd_wb  = rd_of(i_ir_wb);

  assign o_fwd_a = fwd_sel(rs1_of(i_ir_ex), i_ctr_mem[CTR_REGWRITE], w_rd_mem,
                           i_ctr_wb[CTR_REGWRITE], w_rd_wb);
  assign o_fwd_b = fwd_sel(rs2_of(i_ir_ex), i_ctr_mem[CTR_REGWRITE], w_rd_mem,
                           i_ctr_wb[CTR_REGWRITE], w_rd_wb);

  assign w_unused = ^{i_ir_ex[31:25], i_ir_ex[14:0],
                      i_ir_mem[31:12], i_ir_mem[6:0], i_ctr_mem[6:0],
                      i_ir_wb[31:12], i_ir_wb[6:0], i_ctr_wb[6:0]};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Run control (halt/run/step/breakpoint), load-use and redirect hazard
// handling, per-stage enables/flushes and debug cycle/stall counters.
module pipe_hazard_ctrl import pipe_pkg::*; #(
  parameter bit RUN_ON_RESET = 1'b0,
  parameter int CNT_W        = 32
) (
  input logic               clk_cpu,
  input logic               rstn,
  pipe_hazard_ctrl_if.slave bus
);

  localparam state_t RST_STATE = RUN_ON_RESET ? ST_RUN : ST_HALT;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_bp_skip;
  logic             r_bp_hit;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_bp_match;
  logic             w_adv;
  logic             w_leave_halt;
  logic             w_load_use;
  logic             w_stall;
  logic [4:0]       w_rd_ex;
  logic             w_unused;

  assign w_rd_ex    = rd_of(bus.ir_ex);
  // bp_skip masks the match for the first advancing cycle after a resume,
  // so a halted-on breakpoint PC can be fetched.
  assign w_bp_match = bus.bp_en && (bus.pc_if == bus.bp_addr) && !r_bp_skip;
  assign w_load_use = bus.ctr_ex[CTR_MEMREAD] && (w_rd_ex != 5'd0) &&
                      ((w_rd_ex == rs1_of(bus.ir_id)) || (w_rd_ex == rs2_of(bus.ir_id)));
  assign w_stall    = w_load_use && !bus.pcsrc;

  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_adv        = 1'b0;
    w_leave_halt = 1'b0;
    case (r_state)
      ST_HALT: begin
        if (bus.step_req) begin
          w_state_nxt  = ST_STEP;
          w_leave_halt = 1'b1;
        end else if (bus.run_req) begin
          w_state_nxt  = ST_RUN;
          w_leave_halt = 1'b1;
        end
      end
      ST_RUN: begin
        w_adv = !w_bp_match;
        if (bus.halt_req || w_bp_match) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_STEP: begin
        w_adv       = !w_bp_match;
        w_state_nxt = ST_HALT;
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      r_bp_skip   <= 1'b0;
      r_bp_hit    <= 1'b0;
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_leave_halt) begin
        r_bp_skip <= 1'b1;
      end else if (w_adv) begin
        r_bp_skip <= 1'b0;
      end
      if ((r_state == ST_RUN) && w_bp_match) begin
        r_bp_hit <= 1'b1;
      end else if (w_leave_halt) begin
        r_bp_hit <= 1'b0;
      end
      if (w_adv) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
      if (w_adv && w_stall) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // A load-use stall holds PC and IF/ID and injects a bubble into ID/EX
  // while the older instructions keep draining.
  assign bus.pc_we      = w_adv && !w_stall;
  assign bus.ifid_we    = w_adv && !w_stall;
  assign bus.ifid_flush = w_adv && bus.pcsrc;
  assign bus.idex_we    = w_adv;
  assign bus.idex_flush = w_adv && (bus.pcsrc || w_stall);
  assign bus.exmem_we   = w_adv;
  assign bus.memwb_we   = w_adv;

  assign bus.running   = (r_state == ST_RUN);
  assign bus.halted    = (r_state == ST_HALT);
  assign bus.bp_hit    = r_bp_hit;
  assign bus.cycle_cnt = r_cycle_cnt;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.dbg_state = r_state;

  fwd_unit u_fwd (
    .i_ir_ex   (bus.ir_ex),
    .i_ir_mem  (bus.ir_mem),
    .i_ctr_mem (bus.ctr_mem),
    .i_ir_wb   (bus.ir_wb),
    .i_ctr_wb  (bus.ctr_wb),
    .o_fwd_a   (bus.fwd_a),
    .o_fwd_b   (bus.fwd_b)
  );

  assign w_unused = ^{bus.ir_id[31:25], bus.ir_id[14:0],
                      bus.ctr_ex[7:2], bus.ctr_ex[0]};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed run-control/hazard scenarios, then
// random traffic, all compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  logic clk_cpu;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

  pipe_hazard_ctrl #(.RUN_ON_RESET(1'b0), .CNT_W(32)) dut (
    .clk_cpu (clk_cpu),
    .rstn    (rstn),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  // ---------------- behavioural model ----------------
  // mode: 0 = halted, 1 = free running, 2 = single step
  int          m_mode;
  bit          m_skip;
  bit          m_hit;
  logic [31:0] m_cyc;
  logic [31:0] m_stl;

  function automatic int fld(input logic [31:0] ir, input int lsb);
    return int'((ir >> lsb) & 32'd31);
  endfunction

  function automatic bit mdl_bpm();
    return bus.bp_en && (bus.pc_if == bus.bp_addr) && !m_skip;
  endfunction

  function automatic bit mdl_adv();
    return (m_mode != 0) && !mdl_bpm();
  endfunction

  function automatic bit mdl_lu();
    int rd;
    rd = fld(bus.ir_ex, 7);
    return bus.ctr_ex[1] && rd != 0 &&
           (rd == fld(bus.ir_id, 15) || rd == fld(bus.ir_id, 20));
  endfunction

  // Walk the producers youngest-first; first one writing the register wins.
  function automatic logic [1:0] mdl_fwd(input int rs);
    logic [31:0] irs [2];
    logic        wrs [2];
    irs[0] = bus.ir_mem; wrs[0] = bus.ctr_mem[7];
    irs[1] = bus.ir_wb;  wrs[1] = bus.ctr_wb[7];
    for (int k = 0; k < 2; k++) begin
      if (wrs[k] && fld(irs[k], 7) != 0 && fld(irs[k], 7) == rs)
        return (k == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  always @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      m_mode = 0; m_skip = 0; m_hit = 0; m_cyc = 0; m_stl = 0;
    end else begin
      bit adv, bpm, lu;
      adv = mdl_adv(); bpm = mdl_bpm(); lu = mdl_lu();
      if (adv) m_cyc = m_cyc + 1;
      if (adv && lu && !bus.pcsrc) m_stl = m_stl + 1;
      if (m_mode == 1 && bpm) m_hit = 1;
      if (m_mode == 0 && (bus.run_req || bus.step_req)) begin
        m_hit = 0; m_skip = 1;
      end else if (adv) begin
        m_skip = 0;
      end
      case (m_mode)
        0: m_mode = bus.step_req ? 2 : (bus.run_req ? 1 : 0);
        1: m_mode = (bus.halt_req || bpm) ? 0 : 1;
        default: m_mode = 0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_cpu) begin
    bit adv, stall;
    adv   = mdl_adv();
    stall = mdl_lu() && !bus.pcsrc;
    check("pc_we",      64'(bus.pc_we),      64'(adv && !stall));
    check("ifid_we",    64'(bus.ifid_we),    64'(adv && !stall));
    check("ifid_flush", 64'(bus.ifid_flush), 64'(adv && bus.pcsrc));
    check("idex_we",    64'(bus.idex_we),    64'(adv));
    check("idex_flush", 64'(bus.idex_flush), 64'(adv && (bus.pcsrc || stall)));
    check("exmem_we",   64'(bus.exmem_we),   64'(adv));
    check("memwb_we",   64'(bus.memwb_we),   64'(adv));
    check("fwd_a",      64'(bus.fwd_a),      64'(mdl_fwd(fld(bus.ir_ex, 15))));
    check("fwd_b",      64'(bus.fwd_b),      64'(mdl_fwd(fld(bus.ir_ex, 20))));
    check("running",    64'(bus.running),    64'(m_mode == 1));
    check("halted",     64'(bus.halted),     64'(m_mode == 0));
    check("bp_hit",     64'(bus.bp_hit),     64'(m_hit));
    check("cycle_cnt",  64'(bus.cycle_cnt),  64'(m_cyc));
    check("stall_cnt",  64'(bus.stall_cnt),  64'(m_stl));
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mk_r(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] mk_lw(input int rd, input int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction

  task automatic next_cycle();
    @(posedge clk_cpu);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.run_req = 0; bus.step_req = 0; bus.halt_req = 0;
    bus.bp_en = 0; bus.bp_addr = 0; bus.pc_if = 0;
    bus.ir_id = NOP_INSTR; bus.ir_ex = NOP_INSTR; bus.ctr_ex = 0;
    bus.ir_mem = NOP_INSTR; bus.ctr_mem = 0; bus.ir_wb = NOP_INSTR; bus.ctr_wb = 0;
    bus.pcsrc = 0;
  endtask

  task automatic random_cycle();
    bus.run_req  = ($urandom_range(0, 9) == 0);
    bus.step_req = ($urandom_range(0, 9) == 0);
    bus.halt_req = ($urandom_range(0, 14) == 0);
    bus.ir_id    = mk_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    bus.ir_ex    = ($urandom_range(0, 1) == 1) ? mk_lw($urandom_range(0, 7), $urandom_range(0, 7))
                                               : mk_r($urandom_range(0, 7), $urandom_range(0, 7),
                                                      $urandom_range(0, 7));
    bus.ctr_ex   = 8'($urandom());
    bus.ir_mem   = mk_r($urandom_range(0, 7), 0, 0);
    bus.ctr_mem  = 8'($urandom());
    bus.ir_wb    = mk_r($urandom_range(0, 7), 0, 0);
    bus.ctr_wb   = 8'($urandom());
    bus.pcsrc    = bus.ctr_ex[CTR_BRANCH] && ($urandom_range(0, 2) == 0);
    bus.bp_en    = ($urandom_range(0, 1) == 1);
    bus.bp_addr  = 32'h40;
    bus.pc_if    = 32'h3c + 32'(4 * $urandom_range(0, 2));
    rstn         = ($urandom_range(0, 249) != 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rstn = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    settle();
    check("rst_halted", 64'(bus.halted), 64'd1);
    check("rst_cycle",  64'(bus.cycle_cnt), 64'd0);
    rstn = 1'b1;
    next_cycle();
    settle();
    check("halt_pc_we", 64'(bus.pc_we), 64'd0);

    // three single steps
    for (int i = 0; i < 3; i++) begin
      bus.step_req = 1;
      next_cycle();
      bus.step_req = 0;
      settle();
      check("step_pc_we",  64'(bus.pc_we), 64'd1);
      check("step_halted", 64'(bus.halted), 64'd0);
      next_cycle();
      settle();
      check("after_step_halted", 64'(bus.halted), 64'd1);
    end
    check("step_cycle_cnt", 64'(bus.cycle_cnt), 64'd3);

    // load-use: lw x5 in EX, add x6,x5,x1 in ID
    bus.run_req = 1;
    next_cycle();
    bus.run_req = 0;
    bus.ir_ex = mk_lw(5, 2); bus.ctr_ex = 8'h82; bus.ir_id = mk_r(6, 5, 1);
    settle();
    check("lu_pc_we",      64'(bus.pc_we), 64'd0);
    check("lu_ifid_we",    64'(bus.ifid_we), 64'd0);
    check("lu_idex_flush", 64'(bus.idex_flush), 64'd1);
    check("lu_exmem_we",   64'(bus.exmem_we), 64'd1);
    next_cycle();
    bus.ir_ex = NOP_INSTR; bus.ctr_ex = 0;
    settle();
    check("lu_stall_cnt",  64'(bus.stall_cnt), 64'd1);
    check("lu_after_pcwe", 64'(bus.pc_we), 64'd1);

    // one-cycle redirect
    bus.pcsrc = 1;
    settle();
    check("br_pc_we",      64'(bus.pc_we), 64'd1);
    check("br_ifid_flush", 64'(bus.ifid_flush), 64'd1);
    check("br_idex_flush", 64'(bus.idex_flush), 64'd1);
    next_cycle();
    bus.pcsrc = 0;
    settle();
    check("br_after_flush", 64'(bus.ifid_flush), 64'd0);

    // forwarding priority
    bus.ir_mem = mk_r(7, 1, 2); bus.ctr_mem = 8'h80;
    bus.ir_wb  = mk_r(7, 3, 4); bus.ctr_wb  = 8'h80;
    bus.ir_ex  = mk_r(8, 7, 7);
    settle();
    check("fwd_a_mem", 64'(bus.fwd_a), 64'd2);
    check("fwd_b_mem", 64'(bus.fwd_b), 64'd2);
    bus.ir_mem = mk_r(0, 1, 2);
    settle();
    check("fwd_a_wb", 64'(bus.fwd_a), 64'd1);
    next_cycle();

    // breakpoint at 0x40, then resume through it
    bus.bp_en = 1; bus.bp_addr = 32'h40; bus.pc_if = 32'h3c;
    settle();
    check("bp_pre_pcwe", 64'(bus.pc_we), 64'd1);
    next_cycle();
    bus.pc_if = 32'h40;
    settle();
    check("bp_match_pcwe", 64'(bus.pc_we), 64'd0);
    next_cycle();
    settle();
    check("bp_halted", 64'(bus.halted), 64'd1);
    check("bp_hit_set", 64'(bus.bp_hit), 64'd1);
    bus.run_req = 1;
    next_cycle();
    bus.run_req = 0;
    settle();
    check("bp_resume_pcwe", 64'(bus.pc_we), 64'd1);
    check("bp_hit_clear", 64'(bus.bp_hit), 64'd0);
    next_cycle();
    bus.pc_if = 32'h44;
    settle();
    check("bp_no_rehalt", 64'(bus.running), 64'd1);
    bus.bp_en = 0;

    // halt wins over run
    bus.halt_req = 1; bus.run_req = 1;
    next_cycle();
    bus.halt_req = 0; bus.run_req = 0;
    settle();
    check("halt_prio", 64'(bus.halted), 64'd1);

    // async reset during a step cycle
    bus.step_req = 1;
    next_cycle();
    bus.step_req = 0;
    settle();
    check("in_step", 64'(bus.halted), 64'd0);
    rstn = 1'b0;
    #1;
    check("areset_halted", 64'(bus.halted), 64'd1);
    check("areset_cycle",  64'(bus.cycle_cnt), 64'd0);
    check("areset_pcwe",   64'(bus.pc_we), 64'd0);
    next_cycle();
    rstn = 1'b1;
    next_cycle();

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      random_cycle();
      next_cycle();
    end
    rstn = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
